// File: rtl/tdm_demux_1_to_4_if.sv
// Link-side bundle for the 4-channel TDM demultiplexer: incoming word stream plus
// the published frame and framing status.
interface tdm_demux_1_to_4_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_sync;
  logic [4*WIDTH-1:0] out;
  logic               frame_valid;
  logic               locked;
  logic [1:0]         slot;
  logic               sync_err;

  // Link driver / consumer side
  modport master (
    output in_data,
    output in_valid,
    output in_sync,
    input  out,
    input  frame_valid,
    input  locked,
    input  slot,
    input  sync_err
  );

  // Demultiplexer side
  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sync,
    output out,
    output frame_valid,
    output locked,
    output slot,
    output sync_err
  );
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// Receive end of a 4-slot TDM link: locks to the slot-0 sync flag, gathers one word per
// slot in a shadow buffer and publishes the whole frame atomically on the slot-3 word.
module tdm_demux_1_to_4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tdm_demux_1_to_4_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   sh0_q, sh0_d;
  logic [WIDTH-1:0]   sh1_q, sh1_d;
  logic [WIDTH-1:0]   sh2_q, sh2_d;
  logic [4*WIDTH-1:0] out_q, out_d;
  logic               frame_valid_q, frame_valid_d;
  logic               sync_err_q, sync_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      slot_q        <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        StHunt: begin
          // Non-sync words are silently dropped until the first slot-0 marker.
          if (bus.in_sync) begin
            sh0_d   = bus.in_data;
            slot_d  = 2'd1;
            state_d = StLocked;
          end
        end

        StLocked: begin
          if (bus.in_sync) begin
            // A sync mid-frame drops the partial frame but restarts alignment here.
            sync_err_d = (slot_q != 2'd0);
            sh0_d      = bus.in_data;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = StHunt;
          end else begin
            unique case (slot_q)
              2'd1: begin
                sh1_d  = bus.in_data;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = bus.in_data;
                slot_d = 2'd3;
              end
              default: begin
                // Slot-3 word goes straight to the output; no shadow entry needed.
                out_d         = {bus.in_data, sh2_q, sh1_q, sh0_q};
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
            endcase
          end
        end

        default: begin
          state_d = StHunt;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = (state_q == StLocked);
  assign bus.slot        = slot_q;
  assign bus.sync_err    = sync_err_q;

  a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(frame_valid_q && sync_err_q));

  a_hunt_slot_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StHunt) |-> (slot_q == 2'd0));

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Scoreboard bench for tdm_demux_1_to_4: directed scenarios plus random link traffic
// checked against a queue-based frame model.
module tb_tdm_demux_1_to_4;

  localparam int unsigned W = 8;

  typedef struct packed {
    bit          is_err;
    logic [31:0] frame;
  } ev_t;

  logic clk;
  logic rst_n;

  tdm_demux_1_to_4_if #(.WIDTH(W)) bus ();

  tdm_demux_1_to_4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ev_t          exp_q[$];
  bit           m_locked;
  logic [W-1:0] m_words[$];
  logic [31:0]  m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_words  = {};
    m_out    = '0;
    exp_q    = {};
  endtask

  // Frame-level model: a locked receiver holds the words of the current frame in order.
  task automatic model_word(input bit valid, input bit sync, input logic [W-1:0] data);
    ev_t e;
    if (!valid) return;
    if (!m_locked) begin
      if (sync) begin
        m_locked = 1'b1;
        m_words  = {data};
      end
    end else if (sync) begin
      if (m_words.size() != 0) begin
        e = '{is_err: 1'b1, frame: m_out};
        exp_q.push_back(e);
      end
      m_words = {data};
    end else if (m_words.size() == 0) begin
      e = '{is_err: 1'b1, frame: m_out};
      exp_q.push_back(e);
      m_locked = 1'b0;
    end else begin
      m_words.push_back(data);
      if (m_words.size() == 4) begin
        m_out   = {m_words[3], m_words[2], m_words[1], m_words[0]};
        e       = '{is_err: 1'b0, frame: m_out};
        exp_q.push_back(e);
        m_words = {};
      end
    end
  endtask

  // One link cycle: confirm status from all earlier words, then present the next word.
  task automatic send(input bit valid, input bit sync, input logic [W-1:0] data);
    @(negedge clk);
    chk("locked", {31'd0, bus.locked}, {31'd0, m_locked});
    chk("slot", {30'd0, bus.slot}, m_locked ? m_words.size() : 0);
    chk("out", bus.out, m_out);
    bus.in_valid = valid;
    bus.in_sync  = sync;
    bus.in_data  = valid ? data : W'($urandom);
    model_word(valid, sync, data);
  endtask

  task automatic idle();
    send(1'b0, 1'b0, '0);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.frame_valid || bus.sync_err)) begin
      if (bus.frame_valid && bus.sync_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_overlap: frame_valid and sync_err both 1 at %0t", $time);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: fv=%b err=%b with no event expected at %0t",
                 bus.frame_valid, bus.sync_err, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", {31'd0, bus.sync_err}, {31'd0, e.is_err});
        chk("event_out", bus.out, e.frame);
      end
    end
  end

  initial begin
    bit sync_b;
    bit valid_b;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.out, 32'h0);
    chk("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.sync_err}, 32'd0);
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);
    chk("rst_slot", {30'd0, bus.slot}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic frame
    send(1, 1, 8'h11); send(1, 0, 8'h22); send(1, 0, 8'h33); send(1, 0, 8'h44);
    idle();
    chk("t1_out", bus.out, 32'h44332211);
    chk("t1_locked", {31'd0, bus.locked}, 32'd1);

    // 2: unsynced words ignored in HUNT (fresh reset)
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    send(1, 0, 8'hAA); send(1, 0, 8'hBB); idle();
    chk("t2_hunt_locked", {31'd0, bus.locked}, 32'd0);
    chk("t2_hunt_out", bus.out, 32'h0);
    send(1, 1, 8'h01); send(1, 0, 8'h02); send(1, 0, 8'h03); send(1, 0, 8'h04);
    idle();
    chk("t2_out", bus.out, 32'h04030201);

    // 3: short frame then good frame, back-to-back
    send(1, 1, 8'h01); send(1, 0, 8'h02);
    send(1, 1, 8'h10); send(1, 0, 8'h20); send(1, 0, 8'h30); send(1, 0, 8'h40);
    send(1, 1, 8'h50); send(1, 0, 8'h60); send(1, 0, 8'h70); send(1, 0, 8'h80);
    idle();
    chk("t3_out", bus.out, 32'h80706050);

    // 4: missing sync after complete frame
    send(1, 1, 8'hA1); send(1, 0, 8'hA2); send(1, 0, 8'hA3); send(1, 0, 8'hA4);
    send(1, 0, 8'h55); idle();
    chk("t4_locked", {31'd0, bus.locked}, 32'd0);
    chk("t4_out", bus.out, 32'hA4A3A2A1);

    // 5: idles inside a frame
    send(1, 1, 8'h11); idle(); send(1, 0, 8'h22); idle(); idle();
    send(1, 0, 8'h33); send(1, 0, 8'h44); idle();
    chk("t5_out", bus.out, 32'h44332211);

    // 6: asynchronous reset mid-frame
    send(1, 1, 8'hC1); send(1, 0, 8'hC2); idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out", bus.out, 32'h0);
    chk("t6_locked", {31'd0, bus.locked}, 32'd0);
    chk("t6_slot", {30'd0, bus.slot}, 32'd0);
    chk("t6_fv", {31'd0, bus.frame_valid}, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    send(1, 0, 8'hC3); idle();
    chk("t6_hunt", {31'd0, bus.locked}, 32'd0);

    // Random traffic: mostly well-formed frames with occasional idles and framing faults
    for (int i = 0; i < 600; i++) begin
      valid_b = ($urandom_range(0, 3) != 0);
      if (!m_locked || m_words.size() == 0) sync_b = ($urandom_range(0, 7) != 0);
      else                                   sync_b = ($urandom_range(0, 11) == 0);
      send(valid_b, sync_b, W'($urandom));
    end
    idle(); idle();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
